// File: rtl/line_buffer_ctrl.sv
// Three-row line buffer feeding a 3x3 convolution stage: fills three rows, then
// rotates one row at a time and serves 3-pixel slices of each physical buffer.
module line_buffer_ctrl #(
  parameter int IMG_W = 100,
  parameter int IMG_H = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  pix_in,
  input  logic        pix_valid,
  output logic        in_ready,
  input  logic        rd_en,
  input  logic [6:0]  rd_addr,
  input  logic        row_done,
  output logic [23:0] LB1,
  output logic [23:0] LB2,
  output logic [23:0] LB3,
  output logic [1:0]  k,
  output logic        data_valid,
  output logic        frame_done
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H + 1);
  localparam logic [COL_W-1:0] LAST_COL       = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROWS_PER_FRAME = ROW_W'(IMG_H);
  localparam logic [7:0]       COLS           = 8'(IMG_W);

  typedef enum logic [1:0] {FILL, READY, REFILL} state_e;

  state_e            state_q, state_d;
  logic [COL_W-1:0]  wr_col_q, wr_col_d;
  logic [1:0]        wr_buf_q, wr_buf_d;
  logic [1:0]        k_q, k_d;
  logic [ROW_W-1:0]  rows_q, rows_d;
  logic              frame_done_q, frame_done_d;
  logic [2:0][23:0]  lb_q, lb_d;

  logic [7:0] line_mem [3][IMG_W];

  logic       accept;
  logic       row_end;
  logic [7:0] rd_col;

  assign accept  = pix_valid && in_ready;
  assign row_end = accept && (wr_col_q == LAST_COL);
  assign rd_col  = {1'b0, rd_addr};

  // Columns past the right image edge read as zero padding.
  function automatic logic [7:0] col_pix(input logic [1:0] b, input logic [7:0] col);
    col_pix = 8'h00;
    if (col < COLS) col_pix = line_mem[b][col[COL_W-1:0]];
  endfunction

  // NOTE: the line memories have no reset branch; their contents are don't-care
  // until a full fill has overwritten them, and a reset would block RAM mapping.
  always_ff @(posedge clk) begin
    if (accept) line_mem[wr_buf_q][wr_col_q] <= pix_in;
  end

  // NOTE: all state updates use non-blocking assignment so every flop samples
  // the pre-edge values, which also gives read-old-data on write/read collisions.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= FILL;
      wr_col_q     <= '0;
      wr_buf_q     <= '0;
      k_q          <= '0;
      rows_q       <= '0;
      frame_done_q <= 1'b0;
      lb_q         <= '0;
    end else begin
      state_q      <= state_d;
      wr_col_q     <= wr_col_d;
      wr_buf_q     <= wr_buf_d;
      k_q          <= k_d;
      rows_q       <= rows_d;
      frame_done_q <= frame_done_d;
      lb_q         <= lb_d;
    end
  end

  always_comb begin
    // NOTE: every target gets a default first so no path through the case infers a latch.
    state_d      = state_q;
    wr_col_d     = wr_col_q;
    wr_buf_d     = wr_buf_q;
    k_d          = k_q;
    rows_d       = rows_q;
    frame_done_d = 1'b0;

    if (accept)  wr_col_d = row_end ? '0 : wr_col_q + 1'b1;
    if (row_end) rows_d   = rows_q + 1'b1;

    unique case (state_q)
      FILL: begin
        if (row_end) begin
          if (wr_buf_q == 2'd2) begin
            state_d = READY;
            k_d     = 2'd0;
          end else begin
            wr_buf_d = wr_buf_q + 2'd1;
          end
        end
      end
      READY: begin
        if (row_done) begin
          if (rows_q < ROWS_PER_FRAME) begin
            state_d  = REFILL;
            wr_buf_d = k_q;
          end else begin
            state_d      = FILL;
            frame_done_d = 1'b1;
            rows_d       = '0;
            wr_col_d     = '0;
            wr_buf_d     = '0;
            k_d          = '0;
          end
        end
      end
      REFILL: begin
        // The refilled buffer becomes the new bottom row, so the top moves on by one.
        if (row_end) begin
          state_d = READY;
          k_d     = (k_q == 2'd2) ? 2'd0 : k_q + 2'd1;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    lb_d = lb_q;
    if (rd_en) begin
      for (int b = 0; b < 3; b++) begin
        lb_d[b] = {col_pix(2'(b), rd_col),
                   col_pix(2'(b), rd_col + 8'd1),
                   col_pix(2'(b), rd_col + 8'd2)};
      end
    end
  end

  always_comb begin
    in_ready   = (state_q != READY);
    data_valid = (state_q == READY);
  end

  assign LB1        = lb_q[0];
  assign LB2        = lb_q[1];
  assign LB3        = lb_q[2];
  assign k          = k_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Randomised scoreboard bench for line_buffer_ctrl: a row/column-count model of
// the frame predicts status outputs and window reads, a monitor compares them.
module tb_line_buffer_ctrl;

  localparam int W = 100;
  localparam int H = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  pix_in = '0;
  logic        pix_valid = 1'b0;
  logic        in_ready;
  logic        rd_en = 1'b0;
  logic [6:0]  rd_addr = '0;
  logic        row_done = 1'b0;
  logic [23:0] LB1, LB2, LB3;
  logic [1:0]  k;
  logic        data_valid;
  logic        frame_done;

  line_buffer_ctrl #(.IMG_W(W), .IMG_H(H)) dut (
    .clk       (clk),
    .rst       (rst),
    .pix_in    (pix_in),
    .pix_valid (pix_valid),
    .in_ready  (in_ready),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .row_done  (row_done),
    .LB1       (LB1),
    .LB2       (LB2),
    .LB3       (LB3),
    .k         (k),
    .data_valid(data_valid),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Frame model: rows accepted, current column, window rows released.
  logic [7:0]  mem_m [3][W];
  int          rows_m = 0;
  int          col_m  = 0;
  int          rel_m  = 0;
  logic        fd_m   = 1'b0;
  logic [71:0] exp_q [$];
  logic        rd_seen = 1'b0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // A window is ready when three rows beyond the released count are resident.
  function automatic logic model_ready();
    return (rows_m >= 3) && (col_m == 0) && (rel_m == rows_m - 3);
  endfunction

  function automatic logic [1:0] model_k();
    return (rows_m >= 3) ? 2'(rows_m % 3) : 2'd0;
  endfunction

  function automatic logic [71:0] model_window(input int a);
    logic [71:0] w;
    for (int b = 0; b < 3; b++)
      for (int j = 0; j < 3; j++)
        w[71 - 24*b - 8*j -: 8] = (a + j < W) ? mem_m[b][a+j] : 8'h00;
    return w;
  endfunction

  task automatic model_update(input logic pv, input logic [7:0] px, input logic rdn);
    fd_m = 1'b0;
    if (model_ready()) begin
      if (rdn) begin
        if (rows_m == H) begin
          fd_m = 1'b1; rows_m = 0; col_m = 0; rel_m = 0;
        end else begin
          rel_m++;
        end
      end
    end else if (pv) begin
      // Row r of a frame always lands in physical buffer r mod 3.
      mem_m[rows_m % 3][col_m] = px;
      col_m++;
      if (col_m == W) begin
        col_m = 0;
        rows_m++;
      end
    end
  endtask

  task automatic step(input logic pv, input logic [7:0] px, input logic rd,
                      input int addr, input logic rdn);
    @(negedge clk);
    pix_valid = pv;
    pix_in    = px;
    rd_en     = rd;
    rd_addr   = 7'(addr);
    row_done  = rdn;
    if (rd) exp_q.push_back(model_window(addr));
    @(posedge clk);
    if (rst) model_update(pv, px, rdn);
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 1'b0, 0, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst    = 1'b0;
    rows_m = 0; col_m = 0; rel_m = 0; fd_m = 1'b0;
    repeat (3) idle();
    #1;
    check("lb1_reset", 72'(LB1), 72'h0);
    check("lb2_reset", 72'(LB2), 72'h0);
    check("lb3_reset", 72'(LB3), 72'h0);
    @(posedge clk);
    #2;
    rst = 1'b1;
  endtask

  // Monitor: window data one cycle after each read, status every cycle.
  always @(posedge clk) rd_seen <= rd_en;

  always @(negedge clk) begin
    if (rd_seen) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL window_orphan: got %0h with no expected entry at %0t", {LB1, LB2, LB3}, $time);
      end else begin
        check("window", 72'({LB1, LB2, LB3}), exp_q.pop_front());
      end
    end
    check("data_valid", 72'(data_valid), 72'(model_ready()));
    check("in_ready",   72'(in_ready),   72'(!model_ready()));
    check("k",          72'(k),          72'(model_k()));
    check("frame_done", 72'(frame_done), 72'(fd_m));
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int windows;
    int guard;
    logic [7:0] v;

    #1 rst = 1'b0;
    do_reset();

    // Fill with value = column; row_done pulses during fill must be ignored.
    for (int i = 0; i < 300; i++) step(1'b1, 8'(i % W), 1'b0, 0, (i % 37) == 5);
    step(1'b0, 8'h00, 1'b1, 0, 1'b0);
    #1;
    check("fill_lb1_a0", 72'(LB1), 72'h000102);
    check("fill_lb2_a0", 72'(LB2), 72'h000102);
    check("fill_lb3_a0", 72'(LB3), 72'h000102);
    step(1'b0, 8'h00, 1'b1, 97, 1'b0);
    #1;
    check("fill_lb2_a97", 72'(LB2), 72'h616263);
    step(1'b0, 8'h00, 1'b1, 99, 1'b0);
    #1;
    check("edge_lb3_a99", 72'(LB3), 72'h630000);

    // Backpressure: pixels offered in READY must not be stored.
    repeat (50) step(1'b1, 8'h55, 1'b0, 0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 0, 1'b0);
    #1;
    check("stall_lb1_a0", 72'(LB1), 72'h000102);

    // Rotation: one refill row of 0xAA into buffer 0.
    step(1'b0, 8'h00, 1'b0, 0, 1'b1);
    windows = 1;
    repeat (W) step(1'b1, 8'hAA, 1'b0, 0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 5, 1'b0);
    #1;
    check("rot_lb1_a5", 72'(LB1), 72'hAAAAAA);

    // Random remainder of the frame with gaps, stray row_done and reads.
    guard = 0;
    while (!fd_m && guard < 60000) begin
      guard++;
      if (model_ready()) begin
        repeat ($urandom_range(0, 3))
          step($urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 1) == 1,
               $urandom_range(0, 127), 1'b0);
        step(1'b0, 8'h00, 1'b0, 0, 1'b1);
        windows++;
      end else begin
        step($urandom_range(0, 3) != 0, 8'($urandom), 1'b0, 0, $urandom_range(0, 15) == 0);
      end
    end
    check("frame_end_seen", 72'(fd_m), 72'h1);
    check("window_rows", 72'(windows), 72'(H - 2));
    idle();
    idle();

    // Reset mid-fill, then a fresh fill of random pixels.
    for (int i = 0; i < 150; i++) step(1'b1, 8'($urandom), 1'b0, 0, 1'b0);
    do_reset();
    for (int i = 0; i < 300; i++) begin
      v = 8'($urandom);
      step(1'b1, v, 1'b0, 0, 1'b0);
    end
    for (int i = 0; i < 20; i++) step(1'b0, 8'h00, 1'b1, $urandom_range(0, 127), 1'b0);
    idle();
    idle();
    check("queue_drained", 72'(exp_q.size()), 72'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
